// File: rtl/count_capture_fifo.sv
// Snapshots count_in on each rising edge of capture into a FWFT FIFO; entry visible 1 cycle after the edge.
// Consumer drains via out_valid/out_ready; captures arriving while full (and not popping) are dropped and flagged.
module count_capture_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     capture,
  input  logic                     out_ready,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  output logic [WIDTH:0]           out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             capture_d;
  logic [WIDTH-1:0] count_prev;
  logic             wrap_pend;
  logic             overflow_q;

  logic cap_edge;
  logic wrap_now;
  logic pop;
  logic push;
  logic drop;

  assign cap_edge = capture & ~capture_d;
  assign wrap_now = (count_in < count_prev);

  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  assign out_valid = ~empty;
  assign level     = level_q;
  assign overflow  = overflow_q;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop  = out_valid & out_ready;
  assign push = cap_edge & (~full | pop);
  assign drop = cap_edge & full & ~pop;

  assign out_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture_d  <= 1'b0;
      count_prev <= '0;
      wrap_pend  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      capture_d  <= capture;
      count_prev <= count_in;
      // Dropped captures keep the wrap history so the next stored entry still reports it.
      wrap_pend  <= push ? 1'b0 : (wrap_pend | wrap_now);

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (push && !pop)
        level_q <= level_q + (AW+1)'(1);
      else if (pop && !push)
        level_q <= level_q - (AW+1)'(1);

      if (drop)
        overflow_q <= 1'b1;
      else if (clr_ovf)
        overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wrap_pend | wrap_now, count_in};
  end

endmodule

// File: doc/count_capture_fifo.md
# count_capture_fifo

Event-capture buffer placed directly downstream of the 4-bit up counter: on each rising edge of a capture strobe it snapshots the current counter value, tags it with a wrap flag, and queues it in a small first-word-fall-through FIFO. A consumer drains the queue through a valid/ready handshake. Overflow is reported with a sticky flag, so firmware or a test bench can timestamp events against the free-running count without losing track of dropped events.

## Interface
- `WIDTH`, default 4: width of the counter value being captured.
- `DEPTH`, default 4: number of FIFO entries; must be a power of two, at least 2.
- `clk`  in  1  rising-edge clock shared with the counter.
- `reset`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `count_in`  in  WIDTH  live counter value from the upstream counter.
- `capture`  in  1  synchronous event strobe. Only its 0→1 transition is used.
- `out_ready`  in  1  consumer ready.
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `out_valid`  out  1  head entry available.
- `out_data`  out  WIDTH+1  head entry, {wrap, count}.
- `level`  out  log2(DEPTH)+1  number of stored entries.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `overflow`  out  1  sticky; set when a capture is dropped.

## Operation
- **Edge detect:** `capture_d` registers `capture`; `cap_edge = capture & ~capture_d`. A strobe held high produces exactly one capture.
- **Wrap detect:** `count_prev` registers `count_in`; `wrap_now = (count_in < count_prev)`, unsigned compare. `wrap_pend` accumulates `wrap_now` between accepted captures.
- **Pop:** `pop = out_valid & out_ready`. The head advances on the clock edge where pop is true.
- **Push:** `push = cap_edge & (~full | pop)`. Push while full is accepted only when a pop occurs in the same cycle; `level` then stays at DEPTH.
- **Entry content:** the written entry is {`wrap_pend | wrap_now`, `count_in`}. On a push, `wrap_pend` clears to 0. Otherwise `wrap_pend <= wrap_pend | wrap_now`.
- **Drop:** when `cap_edge & full & ~pop`, nothing is written, `overflow` is set, and `wrap_pend` keeps accumulating.
- **Overflow clear:** `clr_ovf` clears `overflow`. If a drop happens in the same cycle, the set wins.
- **Level update:** +1 on push only, −1 on pop only, unchanged when both or neither occur.
- **Pointers:** read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- **Output data:** `out_data` shows the head entry combinationally (first-word fall-through). It is forced to 0 when `empty`.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `level`=0, `full`=0, `empty`=1, `overflow`=0. Internally `capture_d`=0, `count_prev`=0, `wrap_pend`=0, pointers=0.
- **Reset assertion:** reset mid-operation empties the FIFO immediately (asynchronous). Stored entries and `overflow` are discarded.
- **Capture latency:** `capture` is first sampled high at clock edge N. The entry is written at edge N, and `out_valid`=1 with `out_data` valid after edge N. Capture-to-valid latency is 1 cycle.
- **Count sampled:** the captured value is `count_in` as sampled at edge N, i.e. the value the counter presented during the cycle before its own update at N.
- **Handshake:**
  - `out_data` is stable while `out_valid`=1 and `out_ready`=0.
  - An entry is consumed at each edge where both are high.
  - `out_ready` may be asserted while empty; this has no effect.
- **Simultaneous push and pop:** allowed when empty-1, mid, or full. On push+pop while `level`=1, the new entry becomes head after the edge.
- **Flags:** `full`, `empty`, `level` and `overflow` are registered or derived from registered state, and update on the edge causing the change.
- **After reset release:** `count_prev`=0, so the first cycle cannot flag a wrap.

## Test plan
1. **Single capture:** hold reset for 2 cycles, then release. Pulse `capture` for 1 cycle while `count_in`=5, with `out_ready`=0. Required: after that edge `out_valid`=1, `out_data`=5'b0_0101, `level`=1. Hold `out_ready`=0 for 3 cycles: data stays stable.
2. **Held strobe:** hold `capture` high for 4 cycles. Required: `level` increments by exactly 1.
3. **Wrap tag:** capture at `count_in`=14. Let the counter run 15→0→1, then capture at 1. Required: second entry = 5'b1_0001, first entry = 5'b0_1110.
4. **Full and overflow:** with `out_ready`=0, apply 5 capture edges at counts 2, 4, 6, 8, 10 with DEPTH=4. Required:
   - `full`=1, `level`=4, `overflow`=1.
   - Draining yields 2, 4, 6, 8 in order.
   - `empty`=1 afterwards.
   - `overflow` stays 1 until `clr_ovf`.
5. **Push and pop while full:** with the FIFO full of 1, 2, 3, 4, assert a capture edge at count 9 together with `out_ready`=1. Required: `level` stays 4, `overflow` stays 0, and the drain order is 2, 3, 4, 9.
6. **Reset mid-operation:** with `level`=3 and `overflow`=1, assert reset asynchronously between clock edges. Required: `out_valid`=0, `empty`=1, `overflow`=0, `out_data`=0 immediately, before the next clock edge.
